// File: rtl/cmac_rx_monitor_if.sv
// AXI-Stream bundle between the RX CDC FIFO, the statistics monitor and user logic.
interface cmac_rx_monitor_if #(
   parameter int DATA_W = 512
);
   localparam int KEEP_W = DATA_W / 8;

   logic [DATA_W-1:0] tdata;
   logic [KEEP_W-1:0] tkeep;
   logic              tuser;
   logic              tlast;
   logic              tvalid;
   logic              tready;

   modport master (output tdata, tkeep, tuser, tlast, tvalid, input tready);
   modport slave  (input tdata, tkeep, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/cmac_rx_monitor.sv
// Per-channel RX monitor: two-entry register slice on the user-side stream plus
// good/bad frame classification and saturating statistics counters.
module cmac_rx_monitor #(
   parameter int          MIN_FRAME_BYTES  = 64,
   parameter int          MAX_FRAME_BYTES  = 9600,
   parameter logic [31:0] GOOD_FRAMES_INIT = '0   // reset value of good_frames
) (
   input  logic              user_clk,
   input  logic              user_resetn,
   input  logic              clear,
   cmac_rx_monitor_if.slave  s_axis,
   cmac_rx_monitor_if.master m_axis,
   output logic [31:0]       good_frames,
   output logic [31:0]       bad_frames,
   output logic [31:0]       runt_frames,
   output logic [31:0]       oversize_frames,
   output logic [47:0]       good_bytes,
   output logic              frame_done,
   output logic [15:0]       last_frame_len
);
   typedef struct packed {
      logic [511:0] tdata;
      logic [63:0]  tkeep;
      logic         tuser;
      logic         tlast;
   } beat_t;

   function automatic logic [6:0] popcount(input logic [63:0] k);
      logic [6:0] n;
      n = '0;
      for (int i = 0; i < 64; i++) n = n + 7'(k[i]);
      return n;
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] c);
      return (c == '1) ? c : c + 32'd1;
   endfunction

   beat_t main_q, skid_q, in_beat;
   logic  main_vld, skid_vld, rdy_q, skid_nxt;
   logic  in_hs, out_hs, frame_end;

   assign in_beat   = {s_axis.tdata, s_axis.tkeep, s_axis.tuser, s_axis.tlast};
   assign in_hs     = s_axis.tvalid & rdy_q;
   assign out_hs    = main_vld & m_axis.tready;
   assign frame_end = in_hs & s_axis.tlast;

   assign s_axis.tready = rdy_q;
   assign m_axis.tvalid = main_vld;
   assign m_axis.tdata  = main_q.tdata;
   assign m_axis.tkeep  = main_q.tkeep;
   assign m_axis.tuser  = main_q.tuser;
   assign m_axis.tlast  = main_q.tlast;

   // Skid fills only when a beat arrives while main is full and stalled.
   assign skid_nxt = skid_vld ? !out_hs : (in_hs & main_vld & !out_hs);

   always_ff @(posedge user_clk or negedge user_resetn) begin
      if (!user_resetn) begin
         main_vld <= 1'b0;
         skid_vld <= 1'b0;
         rdy_q    <= 1'b0;
         main_q   <= '0;
         skid_q   <= '0;
      end else begin
         skid_vld <= skid_nxt;
         rdy_q    <= !skid_nxt;
         if (skid_vld) begin
            if (out_hs) main_q <= skid_q;
         end else if (in_hs) begin
            if (!main_vld || out_hs) begin
               main_q   <= in_beat;
               main_vld <= 1'b1;
            end else begin
               skid_q <= in_beat;
            end
         end else if (out_hs) begin
            main_vld <= 1'b0;
         end
      end
   end

   logic [6:0]  beat_bytes;
   logic [16:0] sum;
   logic [15:0] acc_q, frame_len;
   logic [48:0] bytes_sum;
   logic        fmt_err_q, beat_err, keep_contig, is_runt, is_over, frame_bad;

   assign beat_bytes  = popcount(s_axis.tkeep);
   assign sum         = {1'b0, acc_q} + {10'b0, beat_bytes};
   assign frame_len   = sum[16] ? 16'hFFFF : sum[15:0];
   // Non-zero and of the form 2^n-1: adding one clears every set bit.
   assign keep_contig = (s_axis.tkeep != '0) && ((s_axis.tkeep & (s_axis.tkeep + 64'd1)) == '0);
   assign beat_err    = s_axis.tlast ? !keep_contig : (s_axis.tkeep != '1);
   assign is_runt     = frame_len < 16'(MIN_FRAME_BYTES);
   assign is_over     = frame_len > 16'(MAX_FRAME_BYTES);
   assign frame_bad   = s_axis.tuser | fmt_err_q | beat_err | is_runt | is_over;
   assign bytes_sum   = {1'b0, good_bytes} + {33'b0, frame_len};

   always_ff @(posedge user_clk or negedge user_resetn) begin
      if (!user_resetn) begin
         acc_q           <= '0;
         fmt_err_q       <= 1'b0;
         frame_done      <= 1'b0;
         last_frame_len  <= '0;
         good_frames     <= GOOD_FRAMES_INIT;
         bad_frames      <= '0;
         runt_frames     <= '0;
         oversize_frames <= '0;
         good_bytes      <= '0;
      end else begin
         frame_done <= frame_end;
         if (in_hs) begin
            if (s_axis.tlast) begin
               acc_q          <= '0;
               fmt_err_q      <= 1'b0;
               last_frame_len <= frame_len;
            end else begin
               acc_q     <= frame_len;
               fmt_err_q <= fmt_err_q | beat_err;
            end
         end
         // clear beats a coincident update; the frame is simply not counted.
         if (clear) begin
            good_frames     <= '0;
            bad_frames      <= '0;
            runt_frames     <= '0;
            oversize_frames <= '0;
            good_bytes      <= '0;
         end else if (frame_end) begin
            if (frame_bad) begin
               bad_frames <= sat_inc(bad_frames);
            end else begin
               good_frames <= sat_inc(good_frames);
               good_bytes  <= bytes_sum[48] ? '1 : bytes_sum[47:0];
            end
            if (is_runt) runt_frames     <= sat_inc(runt_frames);
            if (is_over) oversize_frames <= sat_inc(oversize_frames);
         end
      end
   end
endmodule

// File: tb/tb_cmac_rx_monitor.sv
// Bench for cmac_rx_monitor: directed frames plus randomised backpressure, with
// beat and statistics scoreboards checked by independent monitor processes.
module tb_cmac_rx_monitor;
   localparam logic [63:0] ONES = {64{1'b1}};

   typedef struct packed {
      logic [511:0] tdata;
      logic [63:0]  tkeep;
      logic         tuser;
      logic         tlast;
   } beat_t;

   typedef struct packed {
      logic [31:0] good;
      logic [31:0] bad;
      logic [31:0] runt;
      logic [31:0] over;
      logic [47:0] gbytes;
      logic [15:0] len;
   } stat_t;

   logic        user_clk = 1'b0;
   logic        user_resetn = 1'b0;
   logic        clear = 1'b0;
   logic        sat_clear;
   logic [31:0] good_frames, bad_frames, runt_frames, oversize_frames;
   logic [47:0] good_bytes;
   logic        frame_done;
   logic [15:0] last_frame_len;
   logic [31:0] sat_good, sat_bad, sat_runt, sat_over;
   logic [47:0] sat_gbytes;
   logic        sat_done;
   logic [15:0] sat_len;

   always #5 user_clk = ~user_clk;

   cmac_rx_monitor_if #(.DATA_W(512)) s_if ();
   cmac_rx_monitor_if #(.DATA_W(512)) m_if ();
   cmac_rx_monitor_if #(.DATA_W(512)) sat_s ();
   cmac_rx_monitor_if #(.DATA_W(512)) sat_m ();

   assign sat_clear    = 1'b0;
   assign sat_m.tready = 1'b1;

   cmac_rx_monitor dut (
      .user_clk(user_clk), .user_resetn(user_resetn), .clear(clear),
      .s_axis(s_if), .m_axis(m_if),
      .good_frames(good_frames), .bad_frames(bad_frames), .runt_frames(runt_frames),
      .oversize_frames(oversize_frames), .good_bytes(good_bytes),
      .frame_done(frame_done), .last_frame_len(last_frame_len));

   cmac_rx_monitor #(.GOOD_FRAMES_INIT(32'hFFFF_FFFF)) sat_dut (
      .user_clk(user_clk), .user_resetn(user_resetn), .clear(sat_clear),
      .s_axis(sat_s), .m_axis(sat_m),
      .good_frames(sat_good), .bad_frames(sat_bad), .runt_frames(sat_runt),
      .oversize_frames(sat_over), .good_bytes(sat_gbytes),
      .frame_done(sat_done), .last_frame_len(sat_len));

   int    tests = 0, fails = 0;
   int    cyc = 0, acc_cnt = 0, del_cnt = 0, max_if = 0;
   bit    bp_rand = 1'b0, chk_lat = 1'b0;
   beat_t sb_q[$], fq[$];
   int    acc_t_q[$];
   stat_t st_q[$];
   logic [31:0] mg, mb, mr, mo;
   logic [47:0] mgb;
   int    cur_len;
   bit    cur_fmt, cur_clr;
   beat_t hold_b;
   bit    hold_v = 1'b0;

   task automatic summary();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
   endtask

   task automatic abort(input string what);
      tests++;
      fails++;
      $display("FAIL %s: bound expired, got no handshake, required one", what);
      summary();
      $finish;
   endtask

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h required %0h", name, got, exp);
      end
   endtask

   task automatic chk_stat(input string name, input stat_t got, input stat_t exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got good=%0h bad=%0h runt=%0h over=%0h bytes=%0h len=%0d required good=%0h bad=%0h runt=%0h over=%0h bytes=%0h len=%0d",
                  name, got.good, got.bad, got.runt, got.over, got.gbytes, got.len,
                  exp.good, exp.bad, exp.runt, exp.over, exp.gbytes, exp.len);
      end
   endtask

   task automatic chk_beat(input string name, input beat_t got, input beat_t exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got keep=%h last=%b user=%b data=%h required keep=%h last=%b user=%b data=%h",
                  name, got.tkeep, got.tlast, got.tuser, got.tdata, exp.tkeep, exp.tlast, exp.tuser, exp.tdata);
      end
   endtask

   function automatic logic [31:0] inc32(input logic [31:0] c);
      return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
   endfunction

   function automatic beat_t mk(input logic [63:0] keep, input bit last, input bit user);
      beat_t b;
      for (int i = 0; i < 16; i++) b.tdata[i*32 +: 32] = $urandom;
      b.tkeep = keep;
      b.tlast = last;
      b.tuser = user;
      return b;
   endfunction

   task automatic model_frame_end(input bit user);
      bit bad;
      bad = user | cur_fmt | (cur_len < 64) | (cur_len > 9600);
      if (cur_clr) begin
         mg = '0; mb = '0; mr = '0; mo = '0; mgb = '0;
      end else begin
         if (bad) mb = inc32(mb);
         else begin
            mg  = inc32(mg);
            mgb = mgb + 48'(cur_len);
         end
         if (cur_len < 64)   mr = inc32(mr);
         if (cur_len > 9600) mo = inc32(mo);
      end
      st_q.push_back({mg, mb, mr, mo, mgb, 16'(cur_len)});
   endtask

   // Called at a negedge; the beat is taken on the following posedge once tready is seen.
   task automatic drive_beat(input beat_t b);
      int n;
      n = 0;
      s_if.tdata  = b.tdata;
      s_if.tkeep  = b.tkeep;
      s_if.tuser  = b.tuser;
      s_if.tlast  = b.tlast;
      s_if.tvalid = 1'b1;
      while (s_if.tready !== 1'b1) begin
         @(negedge user_clk);
         n++;
         if (n > 1000) abort("s_tready_wait");
      end
      sb_q.push_back(b);
      acc_t_q.push_back(cyc);
      acc_cnt++;
      if (b.tlast) begin
         model_frame_end(b.tuser);
         if (cur_clr) clear = 1'b1;
      end
      @(negedge user_clk);
      clear       = 1'b0;
      s_if.tvalid = 1'b0;
   endtask

   task automatic send_frame(input int len, input bit fmt, input bit clr, input bit gaps);
      cur_len = len;
      cur_fmt = fmt;
      cur_clr = clr;
      foreach (fq[i]) begin
         drive_beat(fq[i]);
         if (gaps && $urandom_range(0, 3) == 0) @(negedge user_clk);
      end
      fq.delete();
   endtask

   always @(posedge user_clk) begin
      cyc <= cyc + 1;
      if (acc_cnt - del_cnt > max_if) max_if <= acc_cnt - del_cnt;
   end

   always @(posedge user_clk) begin
      #2;
      m_if.tready <= bp_rand ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Output beat monitor: order/content against the scoreboard, stability under stall.
   always @(negedge user_clk) begin
      beat_t got, e;
      int    t;
      got = {m_if.tdata, m_if.tkeep, m_if.tuser, m_if.tlast};
      if (!user_resetn) begin
         hold_v = 1'b0;
      end else begin
         if (hold_v) begin
            chk("m_stall_valid", 64'(m_if.tvalid), 64'd1);
            chk_beat("m_stall_stable", got, hold_b);
         end
         if (m_if.tvalid && m_if.tready) begin
            if (sb_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL m_unexpected: got keep=%h, required no beat", got.tkeep);
            end else begin
               e = sb_q.pop_front();
               t = acc_t_q.pop_front();
               chk_beat("m_beat", got, e);
               if (chk_lat) chk("m_latency", 64'(cyc - t), 64'd1);
            end
            del_cnt++;
         end
         hold_v = m_if.tvalid && !m_if.tready;
         hold_b = got;
      end
   end

   // Statistics monitor: every frame_done pulse consumes one expected record.
   always @(negedge user_clk) begin
      stat_t got, e;
      if (user_resetn && frame_done) begin
         got = {good_frames, bad_frames, runt_frames, oversize_frames, good_bytes, last_frame_len};
         if (st_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL stats_unexpected: got frame_done len=%0d, required no pulse", last_frame_len);
         end else begin
            e = st_q.pop_front();
            chk_stat("stats", got, e);
         end
      end
   end

   initial begin
      int nb, n;
      bit u;
      logic [63:0] k;
      s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tuser = 1'b0; s_if.tlast = 1'b0;
      sat_s.tvalid = 1'b0; sat_s.tdata = '0; sat_s.tkeep = '0; sat_s.tuser = 1'b0; sat_s.tlast = 1'b0;
      mg = '0; mb = '0; mr = '0; mo = '0; mgb = '0;
      cur_len = 0; cur_fmt = 1'b0; cur_clr = 1'b0;

      repeat (3) @(negedge user_clk);
      chk("reset_frames", {good_frames, bad_frames}, 64'd0);
      chk("reset_runt_over", {runt_frames, oversize_frames}, 64'd0);
      chk("reset_bytes_len", {good_bytes, last_frame_len}, 64'd0);
      chk("reset_flags", {61'd0, frame_done, m_if.tvalid, s_if.tready}, 64'd0);
      chk("sat_reset_good", 64'(sat_good), 64'hFFFF_FFFF);
      user_resetn = 1'b1;
      @(negedge user_clk);
      chk("tready_after_reset", 64'(s_if.tready), 64'd1);

      // Partial frame then reset: its 64 bytes must not reach the next frame length.
      fq.push_back(mk(ONES, 1'b0, 1'b0));
      send_frame(0, 1'b0, 1'b0, 1'b0);
      repeat (3) @(negedge user_clk);
      user_resetn = 1'b0;
      mg = '0; mb = '0; mr = '0; mo = '0; mgb = '0;
      @(negedge user_clk);
      user_resetn = 1'b1;
      @(negedge user_clk);

      chk_lat = 1'b1;
      fq.push_back(mk(ONES, 1'b0, 1'b0));
      fq.push_back(mk(ONES, 1'b1, 1'b0));
      send_frame(128, 1'b0, 1'b0, 1'b0);
      repeat (2) @(negedge user_clk);
      chk("f128_good_frames", 64'(good_frames), 64'd1);
      chk("f128_good_bytes", 64'(good_bytes), 64'd128);
      chk("f128_len", 64'(last_frame_len), 64'd128);
      chk("f128_bad_frames", 64'(bad_frames), 64'd0);

      fq.push_back(mk(ONES, 1'b0, 1'b0));
      fq.push_back(mk(64'h1, 1'b1, 1'b1));
      send_frame(65, 1'b0, 1'b0, 1'b0);
      repeat (2) @(negedge user_clk);
      chk("f65_bad_frames", 64'(bad_frames), 64'd1);
      chk("f65_good_frames", 64'(good_frames), 64'd1);
      chk("f65_good_bytes", 64'(good_bytes), 64'd128);
      chk("f65_len", 64'(last_frame_len), 64'd65);

      fq.push_back(mk(64'h0FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0));
      send_frame(60, 1'b0, 1'b0, 1'b0);
      repeat (2) @(negedge user_clk);
      chk("runt_runt_frames", 64'(runt_frames), 64'd1);
      chk("runt_bad_frames", 64'(bad_frames), 64'd2);

      for (int i = 0; i < 150; i++) fq.push_back(mk(ONES, 1'b0, 1'b0));
      fq.push_back(mk(ONES, 1'b1, 1'b0));
      send_frame(9664, 1'b0, 1'b0, 1'b0);
      repeat (2) @(negedge user_clk);
      chk("over_oversize_frames", 64'(oversize_frames), 64'd1);
      chk("over_bad_frames", 64'(bad_frames), 64'd3);
      chk("over_len", 64'(last_frame_len), 64'd9664);

      fq.push_back(mk(ONES, 1'b0, 1'b0));
      fq.push_back(mk(64'hF0F, 1'b1, 1'b0));
      send_frame(72, 1'b1, 1'b0, 1'b0);
      fq.push_back(mk(64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0));
      fq.push_back(mk(ONES, 1'b1, 1'b0));
      send_frame(127, 1'b1, 1'b0, 1'b0);
      repeat (2) @(negedge user_clk);
      chk("fmt_bad_frames", 64'(bad_frames), 64'd5);
      chk("fmt_good_frames", 64'(good_frames), 64'd1);
      chk("fmt_runt_frames", 64'(runt_frames), 64'd1);

      fq.push_back(mk(ONES, 1'b1, 1'b0));
      send_frame(64, 1'b0, 1'b1, 1'b0);
      repeat (2) @(negedge user_clk);
      chk("clr_frames", {good_frames, bad_frames}, 64'd0);
      chk("clr_runt_over", {runt_frames, oversize_frames}, 64'd0);
      chk("clr_bytes", 64'(good_bytes), 64'd0);
      chk("clr_len", 64'(last_frame_len), 64'd64);
      fq.push_back(mk(ONES, 1'b1, 1'b0));
      send_frame(64, 1'b0, 1'b0, 1'b0);
      repeat (2) @(negedge user_clk);
      chk("post_clr_good_frames", 64'(good_frames), 64'd1);
      chk("post_clr_good_bytes", 64'(good_bytes), 64'd64);
      chk_lat = 1'b0;

      bp_rand = 1'b1;
      for (int f = 0; f < 1000; f++) begin
         nb = $urandom_range(1, 3);
         n  = $urandom_range(1, 64);
         u  = ($urandom_range(0, 7) == 0);
         for (int b = 0; b < nb - 1; b++) fq.push_back(mk(ONES, 1'b0, 1'b0));
         k = (n == 64) ? ONES : ((64'd1 << n) - 64'd1);
         fq.push_back(mk(k, 1'b1, u));
         send_frame(64 * (nb - 1) + n, 1'b0, 1'b0, 1'b1);
      end
      bp_rand = 1'b0;
      n = 0;
      while ((sb_q.size() != 0 || st_q.size() != 0) && n < 2000) begin
         @(negedge user_clk);
         n++;
      end
      repeat (2) @(negedge user_clk);
      chk("drain_beats", 64'(sb_q.size()), 64'd0);
      chk("drain_stats", 64'(st_q.size()), 64'd0);
      chk("skid_depth", 64'(max_if), 64'd2);
      chk_stat("final_stats",
               {good_frames, bad_frames, runt_frames, oversize_frames, good_bytes, last_frame_len},
               {mg, mb, mr, mo, mgb, 16'(cur_len)});

      sat_s.tdata  = {16{32'hA5A5_5A5A}};
      sat_s.tkeep  = ONES;
      sat_s.tlast  = 1'b1;
      sat_s.tvalid = 1'b1;
      n = 0;
      while (sat_s.tready !== 1'b1) begin
         @(negedge user_clk);
         n++;
         if (n > 100) abort("sat_tready_wait");
      end
      @(negedge user_clk);
      sat_s.tvalid = 1'b0;
      chk("sat_frame_done", 64'(sat_done), 64'd1);
      chk("sat_good_frames", 64'(sat_good), 64'hFFFF_FFFF);
      chk("sat_good_bytes", 64'(sat_gbytes), 64'd64);

      summary();
      $finish;
   end
endmodule
